// File: rtl/noc_net_iface.sv
// Network interface between the MIPS core and its NoC router port: TX words become head+body
// flit pairs, RX flit pairs become words. Optional NI_LOOPBACK_EN short-circuits self-addressed words.
module noc_net_iface #(
  parameter int NODE_ID  = 0,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        proc_valid,
  input  logic [1:0]  dest_add,
  input  logic [31:0] NI_in,
  input  logic        proc_ready_in,
  output logic        mips_ni,
  output logic [31:0] wd_NI,
  output logic [1:0]  rx_src,
  output logic        data_valid,
  output logic        tx_overflow,
  output logic        rx_err,
  output logic [33:0] flit_out,
  output logic        flit_out_valid,
  input  logic        flit_out_ready,
  input  logic [33:0] flit_in,
  input  logic        flit_in_valid,
  output logic        flit_in_ready
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int TXC = TXA + 1;
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int RXC = RXA + 1;
  localparam logic [1:0]     NODE_ADDR  = 2'(NODE_ID);
  localparam logic [1:0]     FLIT_HEAD  = 2'b01;
  localparam logic [1:0]     FLIT_BODY  = 2'b10;
  localparam logic [TXA-1:0] TX_PTR_ONE = TXA'(1'b1);
  localparam logic [TXC-1:0] TX_CNT_ONE = TXC'(1'b1);
  localparam logic [RXA-1:0] RX_PTR_ONE = RXA'(1'b1);
  localparam logic [RXC-1:0] RX_CNT_ONE = RXC'(1'b1);

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_HEAD = 2'd1, T_BODY = 2'd2} tx_state_e;
  typedef enum logic {R_HEAD = 1'b0, R_BODY = 1'b1} rx_state_e;

  tx_state_e tx_state_q, tx_state_d;
  rx_state_e rx_state_q, rx_state_d;

  logic [33:0]    tx_mem_q [TX_DEPTH];
  logic [TXA-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TXC-1:0] tx_cnt_q, tx_cnt_d;
  logic [33:0]    rx_mem_q [RX_DEPTH];
  logic [RXA-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RXC-1:0] rx_cnt_q, rx_cnt_d;
  logic [1:0]     rx_src_q, rx_src_d;
  logic           tx_overflow_q, rx_err_q;

  logic        tx_full_s, tx_empty_s, tx_push_s, tx_pop_s;
  logic        rx_full_s, rx_empty_s, rx_push_s, rx_pop_s, rx_err_set_s;
  logic        rx_wr_en_s;
  logic [33:0] rx_wr_data_s;
  logic [33:0] tx_head_s;
  logic [1:0]  tx_dest_s;
  logic [31:0] tx_data_s;

  // Full/empty come from the registered counts so a same-cycle pop never frees a slot.
  assign tx_full_s  = (tx_cnt_q == TXC'(TX_DEPTH));
  assign tx_empty_s = (tx_cnt_q == {TXC{1'b0}});
  assign rx_full_s  = (rx_cnt_q == RXC'(RX_DEPTH));
  assign rx_empty_s = (rx_cnt_q == {RXC{1'b0}});
  assign tx_push_s  = proc_valid && !tx_full_s;
  assign rx_pop_s   = proc_ready_in && !rx_empty_s;
  assign tx_head_s  = tx_mem_q[tx_rd_ptr_q];
  assign tx_dest_s  = tx_head_s[33:32];
  assign tx_data_s  = tx_head_s[31:0];

  assign mips_ni     = tx_full_s;
  assign data_valid  = !rx_empty_s;
  assign wd_NI       = rx_empty_s ? 32'h0000_0000 : rx_mem_q[rx_rd_ptr_q][31:0];
  assign rx_src      = rx_empty_s ? 2'b00 : rx_mem_q[rx_rd_ptr_q][33:32];
  assign tx_overflow = tx_overflow_q;
  assign rx_err      = rx_err_q;

`ifdef NI_LOOPBACK_EN
  logic lb_push_s;
  assign rx_wr_en_s   = rx_push_s || lb_push_s;
  assign rx_wr_data_s = lb_push_s ? {NODE_ADDR, tx_data_s} : {rx_src_q, flit_in[31:0]};
`else
  assign rx_wr_en_s   = rx_push_s;
  assign rx_wr_data_s = {rx_src_q, flit_in[31:0]};
`endif

  // Occupancy next-state for both FIFOs.
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_push_s && !tx_pop_s) begin
      tx_cnt_d = tx_cnt_q + TX_CNT_ONE;
    end else if (!tx_push_s && tx_pop_s) begin
      tx_cnt_d = tx_cnt_q - TX_CNT_ONE;
    end else begin
      tx_cnt_d = tx_cnt_q;
    end
    if (rx_wr_en_s && !rx_pop_s) begin
      rx_cnt_d = rx_cnt_q + RX_CNT_ONE;
    end else if (!rx_wr_en_s && rx_pop_s) begin
      rx_cnt_d = rx_cnt_q - RX_CNT_ONE;
    end else begin
      rx_cnt_d = rx_cnt_q;
    end
  end

  // TX FSM: head flit, body flit, then pop; loopback words bypass the router.
  always_comb begin
    tx_state_d     = tx_state_q;
    tx_pop_s       = 1'b0;
    flit_out_valid = 1'b0;
    flit_out       = 34'h0_0000_0000;
`ifdef NI_LOOPBACK_EN
    lb_push_s      = 1'b0;
`endif
    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty_s) begin
`ifdef NI_LOOPBACK_EN
          if (tx_dest_s == NODE_ADDR) begin
            if (!rx_full_s && !rx_push_s) begin
              tx_pop_s  = 1'b1;
              lb_push_s = 1'b1;
            end else begin
              tx_pop_s  = 1'b0;
            end
          end else begin
            tx_state_d = T_HEAD;
          end
`else
          tx_state_d = T_HEAD;
`endif
        end else begin
          tx_state_d = T_IDLE;
        end
      end
      T_HEAD: begin
        flit_out_valid = 1'b1;
        flit_out       = {FLIT_HEAD, 28'h000_0000, NODE_ADDR, tx_dest_s};
        if (flit_out_ready) begin
          tx_state_d = T_BODY;
        end else begin
          tx_state_d = T_HEAD;
        end
      end
      T_BODY: begin
        flit_out_valid = 1'b1;
        flit_out       = {FLIT_BODY, tx_data_s};
        if (flit_out_ready) begin
          tx_pop_s   = 1'b1;
          tx_state_d = T_IDLE;
        end else begin
          tx_state_d = T_BODY;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  // RX FSM: pair a head with the following body; anything out of order flags rx_err.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_src_d      = rx_src_q;
    rx_push_s     = 1'b0;
    rx_err_set_s  = 1'b0;
    flit_in_ready = 1'b0;
    case (rx_state_q)
      R_HEAD: begin
        flit_in_ready = 1'b1;
        if (flit_in_valid) begin
          case (flit_in[33:32])
            FLIT_HEAD: begin
              rx_src_d   = flit_in[3:2];
              rx_state_d = R_BODY;
            end
            default: rx_err_set_s = 1'b1;
          endcase
        end else begin
          rx_state_d = R_HEAD;
        end
      end
      R_BODY: begin
        flit_in_ready = !rx_full_s;
        if (flit_in_valid && !rx_full_s) begin
          case (flit_in[33:32])
            FLIT_HEAD: begin
              rx_err_set_s = 1'b1;
              rx_src_d     = flit_in[3:2];
            end
            FLIT_BODY: begin
              rx_push_s  = 1'b1;
              rx_state_d = R_HEAD;
            end
            default: rx_err_set_s = 1'b1;
          endcase
        end else begin
          rx_state_d = R_BODY;
        end
      end
      default: rx_state_d = R_HEAD;
    endcase
  end

  // State, pointers, counts and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q    <= T_IDLE;
      rx_state_q    <= R_HEAD;
      tx_wr_ptr_q   <= {TXA{1'b0}};
      tx_rd_ptr_q   <= {TXA{1'b0}};
      tx_cnt_q      <= {TXC{1'b0}};
      rx_wr_ptr_q   <= {RXA{1'b0}};
      rx_rd_ptr_q   <= {RXA{1'b0}};
      rx_cnt_q      <= {RXC{1'b0}};
      rx_src_q      <= 2'b00;
      tx_overflow_q <= 1'b0;
      rx_err_q      <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_src_q      <= rx_src_d;
      tx_overflow_q <= tx_overflow_q || (proc_valid && tx_full_s);
      rx_err_q      <= rx_err_q || rx_err_set_s;
      if (tx_push_s) tx_wr_ptr_q <= tx_wr_ptr_q + TX_PTR_ONE;
      if (tx_pop_s)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_PTR_ONE;
      if (rx_wr_en_s) rx_wr_ptr_q <= rx_wr_ptr_q + RX_PTR_ONE;
      if (rx_pop_s)   rx_rd_ptr_q <= rx_rd_ptr_q + RX_PTR_ONE;
    end
  end

  // FIFO storage; contents are only visible through the occupancy-gated outputs.
  always_ff @(posedge clk) begin
    if (!rst && tx_push_s) tx_mem_q[tx_wr_ptr_q] <= {dest_add, NI_in};
    if (!rst && rx_wr_en_s) rx_mem_q[rx_wr_ptr_q] <= rx_wr_data_s;
  end

endmodule
